// File: rtl/riscv_pipe_tracker.sv
// riscv_pipe_tracker: in-order issue-to-writeback tracker for the RISC-V core.
// Carries DEPTH stages of {valid, pc, inst, ctrl, result}. Stage 0 captures the
// ALU/CSR/load/divide result at exit; stage MUL_STAGE captures the multiply result
// at exit. A busy stage 0 holds while older stages drain behind a bubble; flush
// kills everything in flight.
//
// Ports:
//   clk, srst_n        clock, synchronous active-low reset
//   issue_*            offered instruction: valid, pc, inst, ctrl {csr,div,mul,store,load,rd_use}
//   issue_stall        freeze all stages
//   flush              kill every in-flight instruction at the next edge
//   *_result, csr_rdata, mem_data, mem_done, div_valid   unit results and completions
//   stall              stage 0 busy, issue must not advance
//   fwd_rd/data/ok     per-stage forwarding taps (slice k = stage k)
//   wb_*               writeback commit of stage DEPTH-1
module riscv_pipe_tracker #(
    parameter int unsigned DEPTH     = 3,
    parameter int unsigned XLEN      = 32,
    parameter int unsigned MUL_STAGE = 1
) (
    input  logic                    clk,
    input  logic                    srst_n,
    input  logic                    issue_valid,
    input  logic [31:0]             issue_pc,
    input  logic [31:0]             issue_inst,
    input  logic [5:0]              issue_ctrl,
    input  logic                    issue_stall,
    input  logic                    flush,
    input  logic [XLEN-1:0]         alu_result,
    input  logic [XLEN-1:0]         csr_rdata,
    input  logic [XLEN-1:0]         mem_data,
    input  logic [XLEN-1:0]         div_result,
    input  logic [XLEN-1:0]         mul_result,
    input  logic                    mem_done,
    input  logic                    div_valid,
    output logic                    stall,
    output logic [5*DEPTH-1:0]      fwd_rd,
    output logic [XLEN*DEPTH-1:0]   fwd_data,
    output logic [DEPTH-1:0]        fwd_ok,
    output logic                    wb_valid,
    output logic [4:0]              wb_rd,
    output logic [XLEN-1:0]         wb_data,
    output logic [31:0]             wb_pc,
    output logic [31:0]             wb_inst
);

    localparam int unsigned CtrlRdUse = 0;
    localparam int unsigned CtrlLoad  = 1;
    localparam int unsigned CtrlStore = 2;
    localparam int unsigned CtrlMul   = 3;
    localparam int unsigned CtrlDiv   = 4;
    localparam int unsigned CtrlCsr   = 5;

    logic [DEPTH-1:0] valid_q;
    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      inst_q [DEPTH];
    logic [5:0]       ctrl_q [DEPTH];
    // Stage 0 has no result register: its result is the exit mux below.
    logic [XLEN-1:0]  res_q  [1:DEPTH-1];

    logic             busy0;
    logic [XLEN-1:0]  exit0;

    always_comb begin
        busy0 = valid_q[0] &
                (((ctrl_q[0][CtrlLoad] | ctrl_q[0][CtrlStore]) & ~mem_done) |
                 (ctrl_q[0][CtrlDiv] & ~div_valid));

        // Gated by valid so an empty stage 0 forwards (and hands down) zero.
        exit0 = '0;
        if (valid_q[0]) begin
            if (ctrl_q[0][CtrlDiv]) begin
                exit0 = div_result;
            end else if (ctrl_q[0][CtrlLoad]) begin
                exit0 = mem_data;
            end else if (ctrl_q[0][CtrlCsr]) begin
                exit0 = csr_rdata;
            end else begin
                exit0 = alu_result;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            valid_q <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                pc_q[k]   <= '0;
                inst_q[k] <= '0;
                ctrl_q[k] <= '0;
            end
            for (int unsigned k = 1; k < DEPTH; k++) begin
                res_q[k] <= '0;
            end
        end else if (flush) begin
            // Abandoned divides/memory accesses are simply forgotten.
            valid_q <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                ctrl_q[k] <= '0;
            end
        end else if (!issue_stall) begin
            // Older stages always drain, even while stage 0 is busy.
            for (int unsigned k = 2; k < DEPTH; k++) begin
                valid_q[k] <= valid_q[k-1];
                pc_q[k]    <= pc_q[k-1];
                inst_q[k]  <= inst_q[k-1];
                ctrl_q[k]  <= ctrl_q[k-1];
                res_q[k]   <= (k - 1 == MUL_STAGE && valid_q[k-1] && ctrl_q[k-1][CtrlMul]) ?
                              mul_result : res_q[k-1];
            end

            if (busy0) begin
                valid_q[1] <= 1'b0;
                pc_q[1]    <= '0;
                inst_q[1]  <= '0;
                ctrl_q[1]  <= '0;
                res_q[1]   <= '0;
            end else begin
                valid_q[1] <= valid_q[0];
                pc_q[1]    <= pc_q[0];
                inst_q[1]  <= inst_q[0];
                ctrl_q[1]  <= ctrl_q[0];
                res_q[1]   <= exit0;
                valid_q[0] <= issue_valid;
                pc_q[0]    <= issue_valid ? issue_pc   : '0;
                inst_q[0]  <= issue_valid ? issue_inst : '0;
                ctrl_q[0]  <= issue_valid ? issue_ctrl : '0;
            end
        end
    end

    always_comb begin
        stall    = busy0;
        fwd_rd   = '0;
        fwd_data = '0;
        fwd_ok   = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            fwd_rd[5*k +: 5] = (valid_q[k] & ctrl_q[k][CtrlRdUse]) ? inst_q[k][11:7] : 5'd0;
            fwd_ok[k] = valid_q[k] & ctrl_q[k][CtrlRdUse] &
                        ~(ctrl_q[k][CtrlMul] & (k <= MUL_STAGE)) &
                        ~((k == 0) & busy0);
        end
        fwd_data[XLEN-1:0] = exit0;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            fwd_data[XLEN*k +: XLEN] = res_q[k];
        end

        // Writeback is still presented in a flush cycle so the redirecting op commits.
        wb_valid = valid_q[DEPTH-1] & ~issue_stall;
        wb_rd    = (wb_valid & ctrl_q[DEPTH-1][CtrlRdUse]) ? inst_q[DEPTH-1][11:7] : 5'd0;
        wb_data  = res_q[DEPTH-1];
        wb_pc    = pc_q[DEPTH-1];
        wb_inst  = inst_q[DEPTH-1];
    end

endmodule

// File: tb/tb_riscv_pipe_tracker.sv
// Self-checking bench for riscv_pipe_tracker: one DEPTH=3 instance (u3) and one
// DEPTH=4, MUL_STAGE=2 instance (u4) driven by the same stimulus.
module tb_riscv_pipe_tracker;

    localparam logic [31:0] ALU_BASE = 32'hA000_0000;
    localparam logic [31:0] CSR_BASE = 32'hC000_0000;
    localparam logic [31:0] MEM_BASE = 32'hD000_0000;
    localparam logic [31:0] DIV_BASE = 32'hE000_0000;
    localparam logic [31:0] MUL_BASE = 32'h5000_0000;

    localparam logic [5:0] C_ALU = 6'b000001;
    localparam logic [5:0] C_LD  = 6'b000011;
    localparam logic [5:0] C_ST  = 6'b000100;
    localparam logic [5:0] C_MUL = 6'b001001;
    localparam logic [5:0] C_DIV = 6'b010001;
    localparam logic [5:0] C_CSR = 6'b100001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        srst_n, issue_valid, issue_stall, flush, mem_done, div_valid;
    logic [31:0] issue_pc, issue_inst;
    logic [5:0]  issue_ctrl;
    logic [31:0] alu_result, csr_rdata, mem_data, div_result, mul_result;

    logic         a_stall, a_wb_valid;
    logic [14:0]  a_fwd_rd;
    logic [95:0]  a_fwd_data;
    logic [2:0]   a_fwd_ok;
    logic [4:0]   a_wb_rd;
    logic [31:0]  a_wb_data, a_wb_pc, a_wb_inst;

    logic         b_stall, b_wb_valid;
    logic [19:0]  b_fwd_rd;
    logic [127:0] b_fwd_data;
    logic [3:0]   b_fwd_ok;
    logic [4:0]   b_wb_rd;
    logic [31:0]  b_wb_data, b_wb_pc, b_wb_inst;

    riscv_pipe_tracker #(.DEPTH(3), .XLEN(32), .MUL_STAGE(1)) u3 (
        .clk(clk), .srst_n(srst_n), .issue_valid(issue_valid), .issue_pc(issue_pc),
        .issue_inst(issue_inst), .issue_ctrl(issue_ctrl), .issue_stall(issue_stall),
        .flush(flush), .alu_result(alu_result), .csr_rdata(csr_rdata), .mem_data(mem_data),
        .div_result(div_result), .mul_result(mul_result), .mem_done(mem_done),
        .div_valid(div_valid), .stall(a_stall), .fwd_rd(a_fwd_rd), .fwd_data(a_fwd_data),
        .fwd_ok(a_fwd_ok), .wb_valid(a_wb_valid), .wb_rd(a_wb_rd), .wb_data(a_wb_data),
        .wb_pc(a_wb_pc), .wb_inst(a_wb_inst)
    );

    riscv_pipe_tracker #(.DEPTH(4), .XLEN(32), .MUL_STAGE(2)) u4 (
        .clk(clk), .srst_n(srst_n), .issue_valid(issue_valid), .issue_pc(issue_pc),
        .issue_inst(issue_inst), .issue_ctrl(issue_ctrl), .issue_stall(issue_stall),
        .flush(flush), .alu_result(alu_result), .csr_rdata(csr_rdata), .mem_data(mem_data),
        .div_result(div_result), .mul_result(mul_result), .mem_done(mem_done),
        .div_valid(div_valid), .stall(b_stall), .fwd_rd(b_fwd_rd), .fwd_data(b_fwd_data),
        .fwd_ok(b_fwd_ok), .wb_valid(b_wb_valid), .wb_rd(b_wb_rd), .wb_data(b_wb_data),
        .wb_pc(b_wb_pc), .wb_inst(b_wb_inst)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic [31:0] data;
    } sb_item_t;

    typedef struct {
        logic        v;
        logic [4:0]  rd;
        logic [5:0]  ctrl;
        logic        exp_wbv;
        logic [4:0]  exp_wbrd;
        logic [14:0] exp_fwd;   // {stage2, stage1, stage0}
    } vec_t;

    sb_item_t sb_q[$];
    vec_t     vecs[9];
    int       checks = 0;
    int       errors = 0;
    int       cyc = 0;

    function automatic logic [31:0] mk_inst(input logic [4:0] rd);
        return {20'h12345, rd, 7'h33};
    endfunction

    function automatic logic [31:0] pc_of(input logic [4:0] rd);
        return 32'h0000_1000 + {25'd0, rd, 2'b00};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_issue(input logic v, input logic [4:0] rd, input logic [5:0] ctrl);
        issue_valid = v;
        issue_pc    = v ? pc_of(rd) : 32'd0;
        issue_inst  = v ? mk_inst(rd) : 32'd0;
        issue_ctrl  = v ? ctrl : 6'd0;
    endtask

    task automatic push_exp(input logic [4:0] rd, input logic [5:0] ctrl, input logic [31:0] d);
        sb_item_t e;
        e.pc   = pc_of(rd);
        e.inst = mk_inst(rd);
        e.rd   = ctrl[0] ? rd : 5'd0;
        e.data = d;
        sb_q.push_back(e);
    endtask

    // Mid-cycle sample point; commits of u3 are matched against the scoreboard.
    task automatic settle();
        sb_item_t e;
        @(negedge clk);
        if (a_wb_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got commit pc %0h expected none", a_wb_pc);
            end else begin
                e = sb_q.pop_front();
                check("sb_pc", a_wb_pc, e.pc);
                check("sb_inst", a_wb_inst, e.inst);
                check("sb_rd", a_wb_rd, e.rd);
                check("sb_data", a_wb_data, e.data);
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
        alu_result = ALU_BASE + cyc;
        csr_rdata  = CSR_BASE + cyc;
        mem_data   = MEM_BASE + cyc;
        div_result = DIV_BASE + cyc;
        mul_result = MUL_BASE + cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive_issue(1'b0, 5'd0, 6'd0);
            settle();
            advance();
        end
    endtask

    initial begin
        int          c_s;
        logic [31:0] d_s1, d_s2;

        vecs[0] = '{1'b1, 5'd5,  C_ALU, 1'b0, 5'd0,  {5'd0,  5'd0,  5'd0}};
        vecs[1] = '{1'b1, 5'd6,  C_ALU, 1'b0, 5'd0,  {5'd0,  5'd0,  5'd5}};
        vecs[2] = '{1'b1, 5'd0,  C_ALU, 1'b0, 5'd0,  {5'd0,  5'd5,  5'd6}};
        vecs[3] = '{1'b1, 5'd8,  C_ST,  1'b1, 5'd5,  {5'd5,  5'd6,  5'd0}};
        vecs[4] = '{1'b1, 5'd10, C_CSR, 1'b1, 5'd6,  {5'd6,  5'd0,  5'd0}};
        vecs[5] = '{1'b0, 5'd0,  6'd0,  1'b1, 5'd0,  {5'd0,  5'd0,  5'd10}};
        vecs[6] = '{1'b0, 5'd0,  6'd0,  1'b1, 5'd0,  {5'd0,  5'd10, 5'd0}};
        vecs[7] = '{1'b0, 5'd0,  6'd0,  1'b1, 5'd10, {5'd10, 5'd0,  5'd0}};
        vecs[8] = '{1'b0, 5'd0,  6'd0,  1'b0, 5'd0,  {5'd0,  5'd0,  5'd0}};

        srst_n = 1'b0;
        issue_stall = 1'b0;
        flush = 1'b0;
        mem_done = 1'b1;
        div_valid = 1'b0;
        drive_issue(1'b0, 5'd0, 6'd0);
        alu_result = ALU_BASE;
        csr_rdata  = CSR_BASE;
        mem_data   = MEM_BASE;
        div_result = DIV_BASE;
        mul_result = MUL_BASE;
        repeat (2) @(posedge clk);
        #1;
        srst_n = 1'b1;

        // Reset state: every output zero even though unit inputs are non-zero.
        settle();
        check("rst_stall", {a_stall, b_stall}, 2'b00);
        check("rst_fwd_rd", {a_fwd_rd, b_fwd_rd}, 35'd0);
        check("rst_fwd_data", a_fwd_data, 96'd0);
        check("rst_fwd_data4", b_fwd_data, 128'd0);
        check("rst_fwd_ok", {a_fwd_ok, b_fwd_ok}, 7'd0);
        check("rst_wb", {a_wb_valid, a_wb_rd, a_wb_data, a_wb_pc, a_wb_inst}, 102'd0);
        check("rst_wb4", {b_wb_valid, b_wb_rd, b_wb_data, b_wb_pc, b_wb_inst}, 102'd0);
        advance();

        // Back-to-back stream on DEPTH=3.
        for (int i = 0; i < 9; i++) begin
            drive_issue(vecs[i].v, vecs[i].rd, vecs[i].ctrl);
            if (vecs[i].v) begin
                push_exp(vecs[i].rd, vecs[i].ctrl,
                         (vecs[i].ctrl == C_CSR) ? CSR_BASE + cyc + 1 : ALU_BASE + cyc + 1);
            end
            settle();
            check($sformatf("vec%0d_wbv", i), a_wb_valid, vecs[i].exp_wbv);
            check($sformatf("vec%0d_wbrd", i), a_wb_rd, vecs[i].exp_wbrd);
            check($sformatf("vec%0d_fwd_rd", i), a_fwd_rd, vecs[i].exp_fwd);
            check($sformatf("vec%0d_stall", i), a_stall, 1'b0);
            advance();
        end
        idle(2);

        // Load held two cycles behind an older ALU op; younger ALU waits behind it.
        drive_issue(1'b1, 5'd3, C_ALU); push_exp(5'd3, C_ALU, ALU_BASE + cyc + 1);
        settle(); advance();
        drive_issue(1'b1, 5'd7, C_LD); push_exp(5'd7, C_LD, 32'hDEAD_BEEF);
        settle(); advance();
        drive_issue(1'b1, 5'd11, C_ALU); mem_done = 1'b0;
        settle();
        check("ld_stall_1", a_stall, 1'b1);
        check("ld_fwd_ok0", a_fwd_ok[0], 1'b0);
        check("ld_fwd_rd0", a_fwd_rd[4:0], 5'd7);
        advance();
        settle();
        check("ld_stall_2", a_stall, 1'b1);
        check("ld_older_wb", {a_wb_valid, a_wb_rd}, {1'b1, 5'd3});
        check("ld_bubble_s1", {a_fwd_rd[9:5], a_fwd_ok[1]}, 6'd0);
        advance();
        mem_done = 1'b1; mem_data = 32'hDEAD_BEEF; push_exp(5'd11, C_ALU, ALU_BASE + cyc + 1);
        settle();
        check("ld_stall_rel", a_stall, 1'b0);
        check("ld_bubble_wb1", a_wb_valid, 1'b0);
        advance();
        drive_issue(1'b0, 5'd0, 6'd0);
        settle();
        check("ld_bubble_wb2", a_wb_valid, 1'b0);
        advance();
        settle();
        check("ld_wb", {a_wb_valid, a_wb_rd}, {1'b1, 5'd7});
        advance();
        settle();
        check("ld_young_wb", {a_wb_valid, a_wb_rd}, {1'b1, 5'd11});
        advance();
        idle(3);

        // Multiply: u3 captures at stage-1 exit, u4 at stage-2 exit.
        drive_issue(1'b1, 5'd9, C_MUL); push_exp(5'd9, C_MUL, 32'h0000_0777);
        settle(); advance();
        drive_issue(1'b0, 5'd0, 6'd0);
        settle();
        check("mul_ok_s0", {b_fwd_ok[0], b_fwd_rd[4:0]}, {1'b0, 5'd9});
        advance();
        mul_result = 32'h0000_0777;
        settle();
        check("mul_ok_s1", {b_fwd_ok[1], a_fwd_ok[1]}, 2'b00);
        advance();
        mul_result = 32'h0000_1234;
        settle();
        check("mul_ok_s2", {b_fwd_ok[2], a_fwd_ok[2]}, 2'b01);
        check("mul_u3_data", a_fwd_data[95:64], 32'h0000_0777);
        advance();
        settle();
        check("mul_ok_s3", b_fwd_ok[3], 1'b1);
        check("mul_wb4", {b_wb_valid, b_wb_rd, b_wb_data}, {1'b1, 5'd9, 32'h0000_1234});
        check("mul_fwd4", b_fwd_data[127:96], 32'h0000_1234);
        advance();
        idle(3);

        // Flush with three ops in flight and a fourth on offer.
        for (int i = 0; i < 3; i++) begin
            drive_issue(1'b1, 5'(12 + i), C_ALU); push_exp(5'(12 + i), C_ALU, ALU_BASE + cyc + 1);
            settle(); advance();
        end
        drive_issue(1'b1, 5'd15, C_ALU); flush = 1'b1;
        settle();
        check("fl_commit", {a_wb_valid, a_wb_rd}, {1'b1, 5'd12});
        advance();
        flush = 1'b0;
        sb_q.delete();
        drive_issue(1'b0, 5'd0, 6'd0);
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("fl_gap%0d", i), {a_wb_valid, b_wb_valid}, 2'b00);
            if (i == 0) check("fl_fwd_clear", {a_fwd_rd, a_fwd_ok}, 18'd0);
            advance();
        end

        // Three-cycle external freeze mid-stream.
        c_s = cyc;
        d_s1 = ALU_BASE + c_s + 1;
        d_s2 = ALU_BASE + c_s + 2;
        drive_issue(1'b1, 5'd16, C_ALU); push_exp(5'd16, C_ALU, d_s1);
        settle(); advance();
        drive_issue(1'b1, 5'd17, C_ALU); push_exp(5'd17, C_ALU, d_s2);
        settle(); advance();
        drive_issue(1'b1, 5'd18, C_ALU); push_exp(5'd18, C_ALU, ALU_BASE + cyc + 4);
        settle(); advance();
        drive_issue(1'b1, 5'd19, C_ALU); issue_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("st_wbv%0d", i), a_wb_valid, 1'b0);
            check($sformatf("st_fwd_rd%0d", i), a_fwd_rd, {5'd16, 5'd17, 5'd18});
            check($sformatf("st_fwd_ok%0d", i), a_fwd_ok, 3'b111);
            check($sformatf("st_fwd_data%0d", i), a_fwd_data[95:32], {d_s1, d_s2});
            advance();
        end
        issue_stall = 1'b0; push_exp(5'd19, C_ALU, ALU_BASE + cyc + 1);
        settle();
        check("st_release_wb", {a_wb_valid, a_wb_rd}, {1'b1, 5'd16});
        advance();
        idle(4);

        // Divide busy for one cycle, then completes.
        drive_issue(1'b1, 5'd21, C_DIV); push_exp(5'd21, C_DIV, DIV_BASE + cyc + 2);
        settle(); advance();
        drive_issue(1'b0, 5'd0, 6'd0);
        settle();
        check("div_busy", a_stall, 1'b1);
        advance();
        div_valid = 1'b1;
        settle();
        check("div_done", a_stall, 1'b0);
        advance();
        div_valid = 1'b0;
        idle(4);

        // Reset while a divide is busy.
        drive_issue(1'b1, 5'd20, C_DIV);
        settle(); advance();
        drive_issue(1'b0, 5'd0, 6'd0);
        settle();
        check("rdiv_busy", a_stall, 1'b1);
        advance();
        srst_n = 1'b0;
        settle(); advance();
        srst_n = 1'b1;
        settle();
        check("rdiv_stall", a_stall, 1'b0);
        check("rdiv_fwd", {a_fwd_rd, a_fwd_ok, a_fwd_data}, 114'd0);
        check("rdiv_wb", {a_wb_valid, a_wb_rd, a_wb_data, a_wb_pc, a_wb_inst}, 102'd0);
        advance();
        div_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("rdiv_quiet%0d", i), {a_stall, a_wb_valid, a_fwd_ok}, 5'd0);
            advance();
        end
        div_valid = 1'b0;

        check("sb_drain", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
